// File: rtl/vga_pkg.sv
// Shared VGA timing definitions: receiver FSM states and default 640x480 timing.
package vga_pkg;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2
  } vga_rx_state_t;

  localparam int DEF_H_TOTAL     = 800;
  localparam int DEF_H_SYNC      = 96;
  localparam int DEF_H_BP        = 48;
  localparam int DEF_H_ACTIVE    = 640;
  localparam int DEF_V_TOTAL     = 521;
  localparam int DEF_V_SYNC      = 2;
  localparam int DEF_V_BP        = 29;
  localparam int DEF_V_ACTIVE    = 480;
  localparam int DEF_LOCK_FRAMES = 2;

  localparam int H_CNT_W = 12;
  localparam int V_CNT_W = 11;
  localparam int COORD_W = 10;

endpackage

// File: rtl/vga_period_cnt.sv
// Period counter for one sync axis: samples an active-low sync on pixel ticks,
// flags its falling edge, and counts advance events between edges (saturating).
// at_end says the count sits on the last position of a nominal period.
module vga_period_cnt
  import vga_pkg::*;
#(
  parameter int W      = H_CNT_W,
  parameter int PERIOD = DEF_H_TOTAL
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         adv,
  input  logic         sync_n,
  output logic [W-1:0] cnt,
  output logic         fall,
  output logic         at_end,
  output logic         seen
);

  logic sync_q;

  assign fall   = en & sync_q & ~sync_n;
  assign at_end = (cnt == W'(PERIOD - 1));

  // Sample sync on ticks; restart the count on a sync fall, otherwise advance and stick at all-ones.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 1'b1;
      cnt    <= '0;
      seen   <= 1'b0;
    end else begin
      if (en) begin
        sync_q <= sync_n;
      end
      if (fall) begin
        cnt  <= '0;
        seen <= 1'b1;
      end else if (adv && (cnt != {W{1'b1}})) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/vga_sync_rx.sv
// VGA timing receiver: measures line/frame periods from hsync/vsync, locks after
// LOCK_FRAMES consecutive good frames, and regenerates coordinates and data-enable.
module vga_sync_rx
  import vga_pkg::*;
#(
  parameter int H_TOTAL     = DEF_H_TOTAL,
  parameter int H_SYNC      = DEF_H_SYNC,
  parameter int H_BP        = DEF_H_BP,
  parameter int H_ACTIVE    = DEF_H_ACTIVE,
  parameter int V_TOTAL     = DEF_V_TOTAL,
  parameter int V_SYNC      = DEF_V_SYNC,
  parameter int V_BP        = DEF_V_BP,
  parameter int V_ACTIVE    = DEF_V_ACTIVE,
  parameter int LOCK_FRAMES = DEF_LOCK_FRAMES
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  input  logic               en,
  input  logic               i_hsync,
  input  logic               i_vsync,
  output logic [COORD_W-1:0] o_x,
  output logic [COORD_W-1:0] o_y,
  output logic               o_de,
  output logic               o_line_start,
  output logic               o_frame_start,
  output logic               o_locked,
  output logic               o_err
);

  localparam int HA0     = H_SYNC + H_BP;
  localparam int VA0     = V_SYNC + V_BP;
  localparam int TIMEOUT = 2 * H_TOTAL;

  logic [H_CNT_W-1:0] h_cnt;
  logic [V_CNT_W-1:0] v_cnt;
  logic               h_fall, v_fall, h_end, v_end, h_seen, v_seen;
  logic               line_bad, bad_line, frame_good, timeout, h_in, v_in;
  logic [3:0]         good_frames;
  logic               err;
  vga_rx_state_t      state;

  // Horizontal: counts pixel ticks between hsync falls.
  vga_period_cnt #(.W(H_CNT_W), .PERIOD(H_TOTAL)) u_h_cnt (
    .clk(i_clk), .rst_n(i_reset_n), .en(en), .adv(en), .sync_n(i_hsync),
    .cnt(h_cnt), .fall(h_fall), .at_end(h_end), .seen(h_seen)
  );

  // Vertical: counts hsync falls between vsync falls; the vsync fall wins a tie.
  vga_period_cnt #(.W(V_CNT_W), .PERIOD(V_TOTAL)) u_v_cnt (
    .clk(i_clk), .rst_n(i_reset_n), .en(en), .adv(h_fall), .sync_n(i_vsync),
    .cnt(v_cnt), .fall(v_fall), .at_end(v_end), .seen(v_seen)
  );

  // A line is bad when its hsync fall arrives early or late; the same-tick bad
  // line must count against the frame being closed by a coincident vsync fall.
  assign bad_line   = h_fall & ~h_end;
  assign frame_good = v_end & ~(line_bad | bad_line);
  assign timeout    = en & ~h_fall & (h_cnt >= H_CNT_W'(TIMEOUT));

  // Sticky bad-line flag, scoped to one frame.
  always_ff @(negedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      line_bad <= 1'b0;
    end else if (v_fall) begin
      line_bad <= 1'b0;
    end else if (bad_line) begin
      line_bad <= 1'b1;
    end
  end

  // Lock FSM; every event is qualified by en, err is a single-clock pulse.
  always_ff @(negedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state       <= SEARCH;
      good_frames <= 4'd0;
      err         <= 1'b0;
    end else begin
      err <= 1'b0;
      if (timeout) begin
        if (state != SEARCH) begin
          err <= 1'b1;
        end
        state       <= SEARCH;
        good_frames <= 4'd0;
      end else begin
        case (state)
          SEARCH: begin
            if (v_fall) begin
              state       <= TRACK;
              good_frames <= 4'd0;
            end
          end
          TRACK: begin
            if (v_fall) begin
              if (frame_good) begin
                good_frames <= good_frames + 4'd1;
                if ((good_frames + 4'd1) == 4'(LOCK_FRAMES)) begin
                  state <= LOCKED;
                end
              end else begin
                good_frames <= 4'd0;
              end
            end
          end
          LOCKED: begin
            if (bad_line || (v_fall && !frame_good)) begin
              state       <= TRACK;
              good_frames <= 4'd0;
              err         <= 1'b1;
            end
          end
          default: begin
            state       <= SEARCH;
            good_frames <= 4'd0;
          end
        endcase
      end
    end
  end

  // Active window decode straight from the count registers (no extra latency).
  assign h_in = (h_cnt >= H_CNT_W'(HA0)) && (h_cnt < H_CNT_W'(HA0 + H_ACTIVE));
  assign v_in = (v_cnt >= V_CNT_W'(VA0)) && (v_cnt < V_CNT_W'(VA0 + V_ACTIVE));

  assign o_x      = h_in ? COORD_W'(h_cnt - H_CNT_W'(HA0)) : '0;
  assign o_y      = v_in ? COORD_W'(v_cnt - V_CNT_W'(VA0)) : '0;
  assign o_locked = (state == LOCKED);
  assign o_de     = o_locked & h_in & v_in;
  assign o_err    = err;

  // h_cnt is also 0 straight out of reset, before any hsync was seen; only a
  // count restarted by a real hsync fall marks a line start.
  assign o_line_start  = h_seen & (h_cnt == '0);
  assign o_frame_start = o_line_start & v_seen & (v_cnt == '0);

endmodule

// File: tb/tb_vga_sync_rx.sv
// Bench for vga_sync_rx at a reduced timing (40x20 ticks per frame) so many frames fit.
module tb_vga_sync_rx;

  localparam int H_T = 40, H_S = 4, H_B = 3, H_A = 30;
  localparam int V_T = 20, V_S = 2, V_B = 3, V_A = 12;
  localparam int LOCK = 2;
  localparam int HA0 = H_S + H_B, VA0 = V_S + V_B;

  logic       clk = 1'b0, rst_n = 1'b0, en = 1'b0, hs = 1'b1, vs = 1'b1;
  logic [9:0] x, y;
  logic       de, ls, fs, lk, er;

  vga_sync_rx #(
    .H_TOTAL(H_T), .H_SYNC(H_S), .H_BP(H_B), .H_ACTIVE(H_A),
    .V_TOTAL(V_T), .V_SYNC(V_S), .V_BP(V_B), .V_ACTIVE(V_A), .LOCK_FRAMES(LOCK)
  ) dut (
    .i_clk(clk), .i_reset_n(rst_n), .en(en), .i_hsync(hs), .i_vsync(vs),
    .o_x(x), .o_y(y), .o_de(de), .o_line_start(ls), .o_frame_start(fs),
    .o_locked(lk), .o_err(er)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      if (bad <= 20) $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model (timestamps and frame bookkeeping) ----------------
  int m_ticks, m_hmark, m_lines, m_state, m_good;   // m_state: 0 search, 1 track, 2 locked
  bit m_hs, m_vs, m_hseen, m_vseen, m_clean, m_err;

  function automatic int m_h();
    return (m_ticks - m_hmark > 4095) ? 4095 : (m_ticks - m_hmark);
  endfunction
  function automatic int m_v();
    return (m_lines > 2047) ? 2047 : m_lines;
  endfunction

  task automatic model_reset();
    m_ticks = 0; m_hmark = 0; m_lines = 0; m_state = 0; m_good = 0;
    m_hs = 1; m_vs = 1; m_hseen = 0; m_vseen = 0; m_clean = 1; m_err = 0;
  endtask

  task automatic model_step(input bit e, input bit h, input bit v);
    bit hf, vf, badl, fgood, tmo;
    int hc, vc;
    m_err = 0;
    if (e) begin
      hc = m_h(); vc = m_v();
      hf = m_hs && !h;
      vf = m_vs && !v;
      badl  = hf && (hc != H_T - 1);
      fgood = (vc == V_T - 1) && m_clean && !badl;
      tmo   = !hf && (hc >= 2 * H_T);
      if (tmo) begin
        m_err = (m_state != 0); m_state = 0; m_good = 0;
      end else if (m_state == 0) begin
        if (vf) begin m_state = 1; m_good = 0; end
      end else if (m_state == 1) begin
        if (vf) begin
          m_good = fgood ? m_good + 1 : 0;
          if (m_good == LOCK) m_state = 2;
        end
      end else if (badl || (vf && !fgood)) begin
        m_state = 1; m_good = 0; m_err = 1;
      end
      m_ticks++;
      if (hf) begin m_hmark = m_ticks; m_hseen = 1; end
      if (vf) begin m_lines = 0; m_vseen = 1; m_clean = 1; end
      else begin
        if (hf) m_lines++;
        if (badl) m_clean = 0;
      end
      m_hs = h; m_vs = v;
    end
  endtask

  task automatic compare_model();
    int hc, vc, ex, ey;
    bit hin, vin, els;
    hc = m_h(); vc = m_v();
    hin = (hc >= HA0) && (hc < HA0 + H_A);
    vin = (vc >= VA0) && (vc < VA0 + V_A);
    ex = hin ? hc - HA0 : 0;
    ey = vin ? vc - VA0 : 0;
    els = m_hseen && (hc == 0);
    chk("x", int'(x), ex);
    chk("y", int'(y), ey);
    chk("de", int'(de), int'((m_state == 2) && hin && vin));
    chk("line_start", int'(ls), int'(els));
    chk("frame_start", int'(fs), int'(els && m_vseen && (vc == 0)));
    chk("locked", int'(lk), int'(m_state == 2));
    chk("err", int'(er), int'(m_err));
  endtask

  // ---------------- stimulus ----------------
  bit en_rand = 0;
  int low_run = 0;
  int row_de, row_err, first_x, first_y, last_x, last_y;
  bit have_first;

  task automatic cycle(input bit h, input bit v, output bit e);
    @(posedge clk);
    compare_model();
    if (de) begin
      row_de++;
      if (!have_first) begin first_x = int'(x); first_y = int'(y); have_first = 1; end
      last_x = int'(x); last_y = int'(y);
    end
    if (er) row_err++;
    if (en_rand && low_run < 3 && $urandom_range(0, 3) == 0) begin e = 0; low_run++; end
    else begin e = 1; low_run = 0; end
    en = e; hs = h; vs = v;
    model_step(e, h, v);
  endtask

  task automatic pixel(input bit h, input bit v);
    bit e;
    do cycle(h, v, e); while (!e);
  endtask

  // One generated frame; line bad_line gets H_T+dl ticks, stuck holds hsync high.
  task automatic run_frame(input int vtot, input int bad_line, input int dl,
                           input bit stuck, input int max_ticks);
    int n = 0;
    for (int l = 0; l < vtot; l++) begin
      for (int p = 0; p < ((l == bad_line) ? H_T + dl : H_T); p++) begin
        if (n == max_ticks) return;
        pixel(stuck ? 1'b1 : (p >= H_S), l >= V_S);
        n++;
      end
    end
  endtask

  task automatic zero_outputs(input string tag);
    chk({tag, "_x"}, int'(x), 0);
    chk({tag, "_y"}, int'(y), 0);
    chk({tag, "_de"}, int'(de), 0);
    chk({tag, "_ls"}, int'(ls), 0);
    chk({tag, "_fs"}, int'(fs), 0);
    chk({tag, "_locked"}, int'(lk), 0);
    chk({tag, "_err"}, int'(er), 0);
  endtask

  task automatic do_reset();
    en = 0; hs = 1; vs = 1; rst_n = 0;
    repeat (3) @(posedge clk);
    #1 zero_outputs("reset");
    model_reset();
    @(posedge clk);
    rst_n = 1;
  endtask

  task automatic clear_stats();
    row_de = 0; row_err = 0; have_first = 0;
    first_x = -1; first_y = -1; last_x = -1; last_y = -1;
  endtask

  typedef struct {
    int vtot; int bad_line; int stuck;
    int exp_locked; int exp_err; int exp_de;
  } row_t;
  row_t rows[19];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not finish, elapsed %0t", $time);
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    // vtot, bad line (length H_T-1), hsync stuck, locked at end, err pulses, de count (-1 skip)
    rows[0]  = '{V_T, -1, 0, 0, 0, 0};        // first vsync fall: SEARCH -> TRACK
    rows[1]  = '{V_T, -1, 0, 0, 0, 0};        // one good frame
    rows[2]  = '{V_T, -1, 0, 1, 0, H_A*V_A};  // locked at the 3rd vsync fall
    rows[3]  = '{V_T, -1, 0, 1, 0, H_A*V_A};
    rows[4]  = '{V_T,  5, 0, 0, 1, H_A};      // short line: immediate loss of lock
    rows[5]  = '{V_T, -1, 0, 0, 0, 0};        // frame carrying the bad line is rejected
    rows[6]  = '{V_T, -1, 0, 0, 0, 0};
    rows[7]  = '{V_T, -1, 0, 1, 0, H_A*V_A};  // re-locked after 2 further good frames
    rows[8]  = '{V_T, -1, 1, 0, 1, 0};        // hsync stuck: timeout to SEARCH
    rows[9]  = '{V_T, -1, 0, 0, 0, -1};
    rows[10] = '{V_T, -1, 0, 0, 0, -1};
    rows[11] = '{V_T, -1, 0, 1, 0, H_A*V_A};  // locked after 3 vsync falls
    rows[12] = '{V_T,  3, 0, 0, 1, 0};
    rows[13] = '{V_T, -1, 0, 0, 0, 0};
    rows[14] = '{V_T-1, -1, 0, 0, 0, 0};      // short frame while good_frames==1
    rows[15] = '{V_T, -1, 0, 0, 0, 0};        // rejected silently
    rows[16] = '{V_T, -1, 0, 0, 0, 0};
    rows[17] = '{V_T, -1, 0, 1, 0, H_A*V_A};
    rows[18] = '{V_T, -1, 0, 1, 0, H_A*V_A};

    do_reset();
    for (int i = 0; i < 19; i++) begin
      clear_stats();
      run_frame(rows[i].vtot, rows[i].bad_line, -1, rows[i].stuck != 0, 1 << 30);
      @(negedge clk); #1;
      chk($sformatf("row%0d_locked", i), int'(lk), rows[i].exp_locked);
      chk($sformatf("row%0d_err_pulses", i), row_err, rows[i].exp_err);
      if (rows[i].exp_de >= 0) chk($sformatf("row%0d_de_count", i), row_de, rows[i].exp_de);
      if (rows[i].exp_de == H_A * V_A) begin
        chk($sformatf("row%0d_first_x", i), first_x, 0);
        chk($sformatf("row%0d_first_y", i), first_y, 0);
        chk($sformatf("row%0d_last_x", i), last_x, H_A - 1);
        chk($sformatf("row%0d_last_y", i), last_y, V_A - 1);
      end
    end

    // Reset asserted mid active area: outputs drop without waiting for a clock.
    run_frame(V_T, -1, 0, 0, 8 * H_T + 20);
    @(negedge clk); #1;
    chk("de_before_reset", int'(de), 1);
    rst_n = 0;
    #1 zero_outputs("async_reset");
    do_reset();
    for (int f = 0; f < 3; f++) begin
      clear_stats();
      run_frame(V_T, -1, 0, 0, 1 << 30);
      @(negedge clk); #1;
      chk($sformatf("relock_f%0d_locked", f), int'(lk), (f == 2) ? 1 : 0);
      if (f < 2) chk($sformatf("relock_f%0d_de", f), row_de, 0);
    end

    // Randomised pixel-enable gaps and timing faults, checked against the model every clock.
    en_rand = 1;
    for (int f = 0; f < 10; f++) begin
      int bl, dl, vt;
      bit st;
      bl = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, V_T - 1)) : -1;
      dl = ($urandom_range(0, 1) == 0) ? -1 : 1;
      vt = ($urandom_range(0, 4) == 0) ? V_T - 1 : V_T;
      st = ($urandom_range(0, 9) == 0);
      run_frame(vt, bl, dl, st, 1 << 30);
    end
    for (int f = 0; f < 3; f++) run_frame(V_T, -1, 0, 0, 1 << 30);
    @(negedge clk); #1;
    chk("random_end_locked", int'(lk), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
